mem_copy_engine: RTL

Byte-block copy engine that sits directly upstream of the data memory and owns its single address/data/write port. When idle, it passes the core's load/store signals straight through to memory. On `start`, it takes the port and copies `len` bytes from `src_addr` to `dst_addr`, one byte every two cycles. The two cycles are a combinational read followed by a clocked write.

---
 rtl/mem_copy_engine_if.sv | 24 ++
 rtl/mem_copy_engine.sv | 112 +++++++++++
 2 files changed

// File: rtl/mem_copy_engine_if.sv
// rtl/mem_copy_engine_if.sv - data memory port bundle between copy engine and memory
interface mem_copy_engine_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) ();
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_write;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_write,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_write,
        output mem_rdata
    );
endinterface

// File: rtl/mem_copy_engine.sv
// rtl/mem_copy_engine.sv - byte-block copy engine owning the data memory port
module mem_copy_engine #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     src_addr,
    input  logic [ADDR_W-1:0]     dst_addr,
    input  logic [7:0]            len,
    input  logic [ADDR_W-1:0]     core_addr_in,
    input  logic [DATA_W-1:0]     core_data_in,
    input  logic                  core_write,
    output logic [DATA_W-1:0]     core_data_out,
    output logic                  busy,
    output logic                  done,
    mem_copy_engine_if.master     mem
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t             state;
    state_t             state_nx;
    logic [ADDR_W-1:0]  src_cur;
    logic [ADDR_W-1:0]  dst_cur;
    logic [7:0]         cnt;
    logic [DATA_W-1:0]  byte_buf;
    logic               wr_int;

    // Loads always see the memory read port, copy or not.
    assign core_data_out = mem.mem_rdata;

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode: one read cycle then one write cycle per byte.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = (len != 8'd0) ? READ : DONE;
            READ:    state_nx = WRITE;
            WRITE:   state_nx = (cnt == 8'd1) ? DONE : READ;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Copy pointers, remaining count and the byte in flight.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            src_cur  <= '0;
            dst_cur  <= '0;
            cnt      <= 8'd0;
            byte_buf <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        src_cur <= src_addr;
                        dst_cur <= dst_addr;
                        cnt     <= len;
                    end
                end
                READ:  byte_buf <= mem.mem_rdata;
                WRITE: begin
                    src_cur <= src_cur + 1'b1;
                    dst_cur <= dst_cur + 1'b1;
                    cnt     <= cnt - 8'd1;
                end
                default: ;
            endcase
        end
    end

    // Status flags registered from the next state so they line up with it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_nx == READ) || (state_nx == WRITE);
            done <= (state_nx == DONE);
        end
    end

    // Memory port mux: core pass-through unless a copy owns the port; the
    // write strobe is gated by reset so nothing commits while RST is high.
    always_comb begin
        mem.mem_addr  = core_addr_in;
        mem.mem_wdata = core_data_in;
        wr_int        = core_write;
        case (state)
            READ: begin
                mem.mem_addr = src_cur;
                wr_int       = 1'b0;
            end
            WRITE: begin
                mem.mem_addr  = dst_cur;
                mem.mem_wdata = byte_buf;
                wr_int        = 1'b1;
            end
            default: ;
        endcase
        mem.mem_write = wr_int & ~RST;
    end
endmodule
